// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer for the lab CPU: fetch, decode, execute, memory wait.
// Optional memory-wait timeout enabled by defining SEQ_CTRL_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   FETCH  | read instruction at PC, load IR on mem_ready
//   DECODE | PC+1, opcode now valid
//   EXEC   | ALU/jump controls, or branch to MEM/HALT
//   MEM    | LOAD/STORE data access at IR[7:0]
//   HALT   | stopped by HALT, illegal opcode or timeout; start resumes
module seq_ctrl #(
    parameter int OP_W    = 4,
    parameter int TMO_CYC = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic [1:0]      pc_ctrl,
    output logic            ir_load,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            addr_sel,
    output logic [1:0]      alu_op,
    output logic            acc_load,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic            tmo_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JZ    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(15);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       illegal_set;
    logic       flags_clr;
    logic       tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        illegal_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (tmo_hit) state_nxt = S_HALT;
            end
            S_DECODE: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_NOP, OP_ADD, OP_SUB, OP_JMP, OP_JZ: state_nxt = S_FETCH;
                    OP_LOAD, OP_STORE:                     state_nxt = S_MEM;
                    OP_HALT:                               state_nxt = S_HALT;
                    default: begin
                        state_nxt   = S_HALT;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready)    state_nxt = S_FETCH;
                else if (tmo_hit) state_nxt = S_HALT;
            end
            S_HALT: begin
                if (start) state_nxt = S_FETCH;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore controls; ir_load and the LOAD accumulator write are qualified by the handshake.
    always_comb begin
        pc_en    = 1'b0;
        pc_ctrl  = 2'b00;
        ir_load  = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        alu_op   = 2'b00;
        acc_load = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd  = 1'b1;
                ir_load = mem_ready;
            end
            S_DECODE: begin
                pc_en   = 1'b1;
                pc_ctrl = 2'b01;
            end
            S_EXEC: begin
                case (opcode)
                    OP_ADD: begin
                        alu_op   = 2'b01;
                        acc_load = 1'b1;
                    end
                    OP_SUB: begin
                        alu_op   = 2'b10;
                        acc_load = 1'b1;
                    end
                    OP_JMP: begin
                        pc_en   = 1'b1;
                        pc_ctrl = 2'b10;
                    end
                    OP_JZ: begin
                        pc_en   = zero;
                        pc_ctrl = zero ? 2'b10 : 2'b00;
                    end
                    default: begin
                        pc_en = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                addr_sel = 1'b1;
                if (opcode == OP_LOAD) begin
                    mem_rd   = 1'b1;
                    acc_load = mem_ready;
                end else if (opcode == OP_STORE) begin
                    mem_wr = 1'b1;
                end
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);
    assign flags_clr = start && ((state == S_IDLE) || (state == S_HALT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (flags_clr) begin
            illegal <= 1'b0;
        end else if (illegal_set) begin
            illegal <= 1'b1;
        end
    end

`ifdef SEQ_CTRL_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       waiting;

    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign tmo_hit = waiting && (tmo_cnt == 8'(TMO_CYC - 1));

    // Restart the count on every state change so FETCH and MEM get independent budgets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= 8'd0;
        end else if (state_nxt != state) begin
            tmo_cnt <= 8'd0;
        end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end else begin
            tmo_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_err <= 1'b0;
        end else if (flags_clr) begin
            tmo_err <= 1'b0;
        end else if (tmo_hit) begin
            tmo_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: models the PC and IR it drives and checks
// per-cycle control traces derived from the instruction-level rules.
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  opcode;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en;
    logic [1:0]  pc_ctrl;
    logic        ir_load;
    logic        mem_rd;
    logic        mem_wr;
    logic        addr_sel;
    logic [1:0]  alu_op;
    logic        acc_load;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        tmo_err;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem_word = 16'h0000;
    logic [15:0] ir_model;
    logic [15:0] pc_model;
    logic [15:0] pc_exp = 16'h0000;

    logic [11:0] exp_tr [64];
    logic [11:0] obs_tr [64];
    int          exp_n;
    logic [11:0] outv;

    seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .pc_ctrl(pc_ctrl), .ir_load(ir_load),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .alu_op(alu_op),
        .acc_load(acc_load), .busy(busy), .halted(halted), .illegal(illegal),
        .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    assign opcode = ir_model[15:12];
    assign outv   = {pc_en, pc_ctrl, ir_load, mem_rd, mem_wr, addr_sel, alu_op, acc_load, busy, halted};

    // Lab-CPU datapath stand-ins: the IR and PC blocks the sequencer controls.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_model <= 16'h0000;
            pc_model <= 16'h0000;
        end else begin
            if (ir_load) ir_model <= mem_word;
            if (pc_en && pc_ctrl == 2'b01) pc_model <= pc_model + 16'd1;
            else if (pc_en && pc_ctrl == 2'b10) pc_model <= {8'h00, ir_model[7:0]};
        end
    end

    function automatic logic [11:0] mk(input logic pe, input logic [1:0] pc, input logic il,
                                       input logic rd, input logic wr, input logic as,
                                       input logic [1:0] alu, input logic al, input logic b,
                                       input logic h);
        return {pe, pc, il, rd, wr, as, alu, al, b, h};
    endfunction

    // Expected control trace of one instruction, plus the PC it should leave behind.
    task automatic build_ref(input logic [15:0] w, input int fw, input int mw, input logic z);
        logic [3:0] op;
        op = w[15:12];
        exp_n = 0;
        for (int i = 0; i < fw; i++) begin
            exp_tr[exp_n] = mk(0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 1, 0); exp_n++;
        end
        exp_tr[exp_n] = mk(0, 2'b00, 1, 1, 0, 0, 2'b00, 0, 1, 0); exp_n++;
        exp_tr[exp_n] = mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 1, 0); exp_n++;
        case (op)
            4'd3:    exp_tr[exp_n] = mk(0, 2'b00, 0, 0, 0, 0, 2'b01, 1, 1, 0);
            4'd4:    exp_tr[exp_n] = mk(0, 2'b00, 0, 0, 0, 0, 2'b10, 1, 1, 0);
            4'd5:    exp_tr[exp_n] = mk(1, 2'b10, 0, 0, 0, 0, 2'b00, 0, 1, 0);
            4'd6:    exp_tr[exp_n] = z ? mk(1, 2'b10, 0, 0, 0, 0, 2'b00, 0, 1, 0)
                                       : mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 0);
            default: exp_tr[exp_n] = mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        endcase
        exp_n++;
        if (op == 4'd1) begin
            for (int i = 0; i < mw; i++) begin
                exp_tr[exp_n] = mk(0, 2'b00, 0, 1, 0, 1, 2'b00, 0, 1, 0); exp_n++;
            end
            exp_tr[exp_n] = mk(0, 2'b00, 0, 1, 0, 1, 2'b00, 1, 1, 0); exp_n++;
        end else if (op == 4'd2) begin
            for (int i = 0; i <= mw; i++) begin
                exp_tr[exp_n] = mk(0, 2'b00, 0, 0, 1, 1, 2'b00, 0, 1, 0); exp_n++;
            end
        end
        if (op == 4'd5 || (op == 4'd6 && z)) pc_exp = {8'h00, w[7:0]};
        else pc_exp = pc_exp + 16'd1;
    endtask

    // Starts one cycle after a posedge with the DUT in FETCH; ends the same way.
    task automatic drive_instr(input logic [15:0] w, input int fw, input int mw, input logic z);
        int n;
        n = fw + 3 + ((w[15:12] == 4'd1 || w[15:12] == 4'd2) ? mw + 1 : 0);
        mem_word = w;
        zero = z;
        for (int i = 0; i < n; i++) begin
            if (i < fw) mem_ready = 1'b0;
            else if (i == fw) mem_ready = 1'b1;
            else if (i < fw + 3) mem_ready = 1'($urandom_range(1, 0));
            else mem_ready = (i - fw - 3 == mw);
            @(negedge clk);
            obs_tr[i] = outv;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if (outv !== 12'h000 || illegal !== 1'b0 || tmo_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %h/%b/%b want 000/0/0", outv, illegal, tmo_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outv !== 12'h000) begin
                failures++;
                $display("FAIL idle_hold cyc %0d: got %h want 000", i, outv);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_nop;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            build_ref(16'h0000, 0, 0, 1'b0);
            drive_instr(16'h0000, 0, 0, 1'b0);
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (obs_tr[i] !== exp_tr[i]) begin
                    failures++;
                    $display("FAIL nop%0d cyc %0d: got %h want %h", k, i, obs_tr[i], exp_tr[i]);
                end
            end
            checks++;
            if (pc_model !== 16'(k + 1)) begin
                failures++;
                $display("FAIL nop_pc%0d: got %h want %h", k, pc_model, 16'(k + 1));
            end
        end
    endtask

    task automatic test_jump;
        logic [15:0] words [3];
        logic        zs [3];
        words[0] = 16'h503C; zs[0] = 1'b0;
        words[1] = 16'h603C; zs[1] = 1'b0;
        words[2] = 16'h603C; zs[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            build_ref(words[k], 0, 0, zs[k]);
            drive_instr(words[k], 0, 0, zs[k]);
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (obs_tr[i] !== exp_tr[i]) begin
                    failures++;
                    $display("FAIL jump%0d cyc %0d: got %h want %h", k, i, obs_tr[i], exp_tr[i]);
                end
            end
            checks++;
            if (pc_model !== pc_exp) begin
                failures++;
                $display("FAIL jump_pc%0d: got %h want %h", k, pc_model, pc_exp);
            end
        end
        checks++;
        if (pc_model !== 16'h003C) begin
            failures++;
            $display("FAIL jz_taken_pc: got %h want 003c", pc_model);
        end
    endtask

    task automatic test_load_wait;
        logic [15:0] words [2];
        words[0] = 16'h1042;
        words[1] = 16'h2099;
        for (int k = 0; k < 2; k++) begin
            build_ref(words[k], 1, 5, 1'b0);
            drive_instr(words[k], 1, 5, 1'b0);
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (obs_tr[i] !== exp_tr[i]) begin
                    failures++;
                    $display("FAIL memwait%0d cyc %0d: got %h want %h", k, i, obs_tr[i], exp_tr[i]);
                end
            end
        end
        checks++;
        if (pc_model !== pc_exp) begin
            failures++;
            $display("FAIL memwait_pc: got %h want %h", pc_model, pc_exp);
        end
    endtask

    task automatic test_random;
        logic [15:0] w;
        int          fw;
        int          mw;
        logic        z;
        for (int k = 0; k < 40; k++) begin
            w  = {4'($urandom_range(6, 0)), 12'($urandom)};
            fw = $urandom_range(3, 0);
            mw = $urandom_range(3, 0);
            z  = 1'($urandom_range(1, 0));
            build_ref(w, fw, mw, z);
            drive_instr(w, fw, mw, z);
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (obs_tr[i] !== exp_tr[i]) begin
                    failures++;
                    $display("FAIL rand%0d op %h cyc %0d: got %h want %h", k, w[15:12], i, obs_tr[i], exp_tr[i]);
                end
            end
            checks++;
            if (pc_model !== pc_exp) begin
                failures++;
                $display("FAIL rand%0d_pc: got %h want %h", k, pc_model, pc_exp);
            end
        end
    endtask

    task automatic test_illegal;
        logic [3:0] ops [3];
        logic [15:0] w;
        ops[0] = 4'hA;
        ops[1] = 4'($urandom_range(14, 7));
        ops[2] = 4'hF;
        for (int k = 0; k < 3; k++) begin
            w = {ops[k], 12'h0A5};
            build_ref(w, 0, 0, 1'b0);
            drive_instr(w, 0, 0, 1'b0);
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (obs_tr[i] !== exp_tr[i]) begin
                    failures++;
                    $display("FAIL halt%0d cyc %0d: got %h want %h", k, i, obs_tr[i], exp_tr[i]);
                end
            end
            @(negedge clk);
            checks++;
            if (outv !== mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1) || illegal !== (ops[k] != 4'hF)) begin
                failures++;
                $display("FAIL halt%0d_state op %h: got %h ill=%b want %h ill=%b", k, ops[k], outv,
                         illegal, mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1), ops[k] != 4'hF);
            end
            @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (outv !== mk(0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 1, 0) || illegal !== 1'b0 || pc_model !== pc_exp) begin
                failures++;
                $display("FAIL resume%0d: got %h ill=%b pc=%h want %h ill=0 pc=%h", k, outv, illegal,
                         pc_model, mk(0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 1, 0), pc_exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid;
        mem_word = 16'h1077;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (outv !== mk(0, 2'b00, 0, 1, 0, 1, 2'b00, 0, 1, 0)) begin
            failures++;
            $display("FAIL mid_in_mem: got %h want %h", outv, mk(0, 2'b00, 0, 1, 0, 1, 2'b00, 0, 1, 0));
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outv !== 12'h000 || illegal !== 1'b0 || tmo_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_async: got %h want 000", outv);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pc_exp = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (outv !== 12'h000) begin
            failures++;
            $display("FAIL mid_reset_idle: got %h want 000", outv);
        end
    endtask

    task automatic test_timeout;
        int rd_cnt;
        int cyc;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
        rd_cnt = 0;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (halted) break;
            if (mem_rd) rd_cnt++;
            cyc++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (rd_cnt != 16 || halted !== 1'b1 || tmo_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout: rd_cycles=%0d halted=%b tmo_err=%b want 16/1/1", rd_cnt, halted, tmo_err);
        end
        checks++;
        if (outv !== mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1)) begin
            failures++;
            $display("FAIL timeout_strobes: got %h want %h", outv, mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1));
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (tmo_err !== 1'b0 || mem_rd !== 1'b1) begin
            failures++;
            $display("FAIL timeout_restart: tmo_err=%b mem_rd=%b want 0/1", tmo_err, mem_rd);
        end
`else
        rd_cnt = 0;
        for (cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (outv === mk(0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 1, 0) && tmo_err === 1'b0) rd_cnt++;
        end
        checks++;
        if (rd_cnt != 100) begin
            failures++;
            $display("FAIL no_timeout: fetch_cycles=%0d want 100 (last %h tmo_err=%b)", rd_cnt, outv, tmo_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_nop();
        test_jump();
        test_load_wait();
        test_random();
        test_illegal();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
